// File: rtl/row_scan_decoder.sv
// row_scan_decoder: time-multiplexed one-hot LED row driver with anti-ghost blanking, hold and manual row select
`ifndef ROW_NUM
`define ROW_NUM 8
`endif
module row_scan_decoder #(
   parameter int ROW_NUM     = `ROW_NUM,
   parameter int SEL_W       = $clog2(ROW_NUM),
   parameter bit ACTIVE_HIGH = 1'b1,
   parameter int DWELL_CYC   = 1000,
   parameter int BLANK_CYC   = 8
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               en_i,
   input  logic               mode_i,
   input  logic [SEL_W-1:0]   sel_i,
   input  logic               hold_i,
   output logic [ROW_NUM-1:0] row_o,
   output logic [SEL_W-1:0]   row_idx_o,
   output logic               row_done_o,
   output logic               frame_start_o,
   output logic               err_o
);
   localparam int MAX_CYC = DWELL_CYC > BLANK_CYC ? DWELL_CYC : BLANK_CYC;
   localparam int CNT_W = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC > 0 ? BLANK_CYC - 1 : 0);
   localparam logic [ROW_NUM-1:0] INACT = ACTIVE_HIGH ? '0 : '1;
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(ROW_NUM - 1);

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic [ROW_NUM-1:0] row_q, row_d;
   logic               manual_q, manual_d;
   logic               fs_q, fs_d;
   logic               err_q, err_d;
   logic               drive_end, blank_end, enter_drive, sel_ok;
   logic [SEL_W-1:0]   base_idx, new_idx;

   // a row finishes only when its dwell count is reached and it is not frozen
   assign drive_end   = (state_q == DRIVE) && !hold_i && (cnt_q == DWELL_LAST);
   assign blank_end   = (state_q == BLANK) && (cnt_q == BLANK_LAST);
   // with no blanking, a row is entered straight from IDLE or from the previous row
   assign enter_drive = en_i && (blank_end || ((BLANK_CYC == 0) && ((state_q == IDLE) || drive_end)));
   assign sel_ok      = int'(sel_i) < ROW_NUM;
   // auto mode advances the index as the row ends, so the following row uses the advanced value
   assign base_idx    = (drive_end && !manual_q) ? ((idx_q == IDX_LAST) ? '0 : idx_q + SEL_W'(1)) : idx_q;
   assign new_idx     = mode_i ? sel_i : base_idx;

   // state register: every output-facing flop clears asynchronously so rows go dark at once
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         row_q    <= INACT;
         manual_q <= 1'b0;
         fs_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         row_q    <= row_d;
         manual_q <= manual_d;
         fs_q     <= fs_d;
         err_q    <= err_d;
      end
   end

   // next state and cycle counter: disable wins, then row entry, then per-state sequencing
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!en_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (enter_drive) begin
         state_d = DRIVE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = BLANK;
               cnt_d   = '0;
            end
            BLANK: cnt_d = cnt_q + CNT_W'(1);
            DRIVE: begin
               if (drive_end) begin
                  state_d = BLANK;
                  cnt_d   = '0;
               end else if (!hold_i) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // registered outputs: row pattern, index, mode latch and the entry pulses
   always_comb begin
      idx_d    = idx_q;
      manual_d = manual_q;
      row_d    = (state_q == DRIVE) ? row_q : INACT;
      fs_d     = 1'b0;
      err_d    = 1'b0;
      if (!en_i) begin
         idx_d = '0;
         row_d = INACT;
      end else if (enter_drive) begin
         manual_d = mode_i;
         if (mode_i && !sel_ok) begin
            idx_d = base_idx;
            row_d = INACT;
            err_d = 1'b1;
         end else begin
            idx_d = new_idx;
            row_d = (ROW_NUM'(1) << new_idx) ^ INACT;
            fs_d  = !mode_i && (base_idx == '0);
         end
      end else if (drive_end) begin
         idx_d = base_idx;
         row_d = INACT;
      end
   end

   assign row_o         = row_q;
   assign row_idx_o     = idx_q;
   assign row_done_o    = en_i && drive_end;
   assign frame_start_o = fs_q;
   assign err_o         = err_q;
endmodule

// File: tb/tb_row_scan_decoder.sv
// tb_row_scan_decoder: three parameterisations driven in lockstep and checked against a cycle model
module tb_row_scan_decoder;
   logic clk = 1'b0;
   logic rst_n, en, mode, hold;
   logic [2:0] sel;
   logic [7:0] row_a, row_b;
   logic [4:0] row_c;
   logic [2:0] idx_a, idx_b, idx_c;
   logic done_a, done_b, done_c, fs_a, fs_b, fs_c, err_a, err_b, err_c;
   logic [13:0] obs [3];
   int checks = 0;
   int failures = 0;
   int P_N [3] = '{8, 8, 5};
   int P_D [3] = '{4, 4, 2};
   int P_B [3] = '{2, 0, 1};
   int P_AH [3] = '{1, 0, 1};
   int ph [3];
   int left [3];
   int idx [3];
   int act [3];
   bit autom [3];
   bit fs_m [3];
   bit er_m [3];

   always #5 clk = ~clk;

   row_scan_decoder #(.ROW_NUM(8), .ACTIVE_HIGH(1), .DWELL_CYC(4), .BLANK_CYC(2)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .mode_i(mode), .sel_i(sel), .hold_i(hold),
      .row_o(row_a), .row_idx_o(idx_a), .row_done_o(done_a), .frame_start_o(fs_a), .err_o(err_a));
   row_scan_decoder #(.ROW_NUM(8), .ACTIVE_HIGH(0), .DWELL_CYC(4), .BLANK_CYC(0)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .mode_i(mode), .sel_i(sel), .hold_i(hold),
      .row_o(row_b), .row_idx_o(idx_b), .row_done_o(done_b), .frame_start_o(fs_b), .err_o(err_b));
   row_scan_decoder #(.ROW_NUM(5), .ACTIVE_HIGH(1), .DWELL_CYC(2), .BLANK_CYC(1)) dut_c (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .mode_i(mode), .sel_i(sel), .hold_i(hold),
      .row_o(row_c), .row_idx_o(idx_c), .row_done_o(done_c), .frame_start_o(fs_c), .err_o(err_c));

   assign obs[0] = {row_a, idx_a, done_a, fs_a, err_a};
   assign obs[1] = {row_b, idx_b, done_b, fs_b, err_b};
   assign obs[2] = {3'b000, row_c, idx_c, done_c, fs_c, err_c};

   // model: phase 0 idle, 1 blanking, 2 driving; left counts remaining cycles of the phase
   function automatic void m_reset(int i);
      ph[i] = 0; left[i] = 0; idx[i] = 0; act[i] = -1;
      autom[i] = 1'b1; fs_m[i] = 1'b0; er_m[i] = 1'b0;
   endfunction

   function automatic void m_drive(int i);
      ph[i] = 2;
      left[i] = P_D[i];
      autom[i] = !mode;
      if (mode) begin
         if (int'(sel) < P_N[i]) begin idx[i] = int'(sel); act[i] = int'(sel); end
         else begin er_m[i] = 1'b1; act[i] = -1; end
      end else begin
         act[i] = idx[i];
         fs_m[i] = (idx[i] == 0);
      end
   endfunction

   function automatic void m_gap(int i);
      if (P_B[i] == 0) m_drive(i);
      else begin ph[i] = 1; left[i] = P_B[i]; act[i] = -1; end
   endfunction

   function automatic void m_step(int i);
      fs_m[i] = 1'b0;
      er_m[i] = 1'b0;
      if (!en) begin
         ph[i] = 0; idx[i] = 0; act[i] = -1;
      end else if (ph[i] == 0) begin
         m_gap(i);
      end else if (ph[i] == 1) begin
         left[i]--;
         if (left[i] == 0) m_drive(i);
      end else if (!hold) begin
         left[i]--;
         if (left[i] == 0) begin
            if (autom[i]) idx[i] = (idx[i] + 1) % P_N[i];
            m_gap(i);
         end
      end
   endfunction

   function automatic logic [13:0] exp_sig(int i);
      logic [7:0] r;
      logic d;
      r = (act[i] >= 0) ? (8'h01 << act[i]) : 8'h00;
      if (P_AH[i] == 0) r = ~r;
      d = (ph[i] == 2) && (left[i] == 1) && !hold && en;
      return {r, 3'(idx[i]), d, fs_m[i], er_m[i]};
   endfunction

   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 3; i++) m_step(i);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; mode = 1'b0; hold = 1'b0; sel = 3'd0;
      repeat (2) @(negedge clk);
      en = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (obs[0] !== 14'h0000) begin failures++; $display("FAIL reset_a: got %h expected %h", obs[0], 14'h0000); end
      checks++;
      if (obs[1] !== {8'hFF, 6'h00}) begin failures++; $display("FAIL reset_b: got %h expected %h", obs[1], {8'hFF, 6'h00}); end
      checks++;
      if (obs[2] !== 14'h0000) begin failures++; $display("FAIL reset_c: got %h expected %h", obs[2], 14'h0000); end
      rst_n = 1'b1;
      en = 1'b0;
      for (int i = 0; i < 3; i++) m_reset(i);
   endtask

   task automatic test_auto_scan();
      logic [7:0] exp_row;
      int nd, nf;
      en = 1'b0; mode = 1'b0; hold = 1'b0; sel = 3'd0;
      tick();
      en = 1'b1; nd = 0; nf = 0;
      for (int c = 0; c < 96; c++) begin
         tick();
         #1;
         exp_row = (c % 6 < 2) ? 8'h00 : (8'h01 << ((c / 6) % 8));
         checks++;
         if (row_a !== exp_row) begin failures++; $display("FAIL auto_row c=%0d: got %h expected %h", c, row_a, exp_row); end
         checks++;
         if (fs_a !== ((c % 6 == 2) && ((c / 6) % 8 == 0))) begin failures++; $display("FAIL auto_frame_start c=%0d: got %b", c, fs_a); end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== exp_sig(i)) begin failures++; $display("FAIL auto_model dut%0d c=%0d: got %h expected %h", i, c, obs[i], exp_sig(i)); end
         end
         nd += int'(done_a);
         nf += int'(fs_a);
      end
      checks++;
      if (nd !== 16) begin failures++; $display("FAIL auto_done_count: got %0d expected 16", nd); end
      checks++;
      if (nf !== 2) begin failures++; $display("FAIL auto_frame_count: got %0d expected 2", nf); end
   endtask

   task automatic test_manual();
      logic [7:0] exp_row;
      en = 1'b0; mode = 1'b1; hold = 1'b0; sel = 3'd5;
      tick();
      en = 1'b1;
      for (int c = 0; c < 24; c++) begin
         tick();
         #1;
         exp_row = (c % 6 < 2) ? 8'h00 : ((c < 18) ? 8'h20 : 8'h04);
         checks++;
         if (row_a !== exp_row) begin failures++; $display("FAIL manual_row c=%0d: got %h expected %h", c, row_a, exp_row); end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== exp_sig(i)) begin failures++; $display("FAIL manual_model dut%0d c=%0d: got %h expected %h", i, c, obs[i], exp_sig(i)); end
         end
         if (c == 15) sel = 3'd2;
      end
   endtask

   task automatic test_hold();
      int n08, nd3;
      en = 1'b0; mode = 1'b0; hold = 1'b0; sel = 3'd0;
      tick();
      en = 1'b1; n08 = 0; nd3 = 0;
      for (int c = 0; c < 50; c++) begin
         tick();
         hold = (c >= 21) && (c < 31);
         #1;
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== exp_sig(i)) begin failures++; $display("FAIL hold_model dut%0d c=%0d: got %h expected %h", i, c, obs[i], exp_sig(i)); end
         end
         if (row_a === 8'h08) begin
            n08++;
            nd3 += int'(done_a);
         end
      end
      hold = 1'b0;
      checks++;
      if (n08 !== 14) begin failures++; $display("FAIL hold_row3_cycles: got %0d expected 14", n08); end
      checks++;
      if (nd3 !== 1) begin failures++; $display("FAIL hold_row3_done: got %0d expected 1", nd3); end
   endtask

   task automatic test_abort();
      en = 1'b0; mode = 1'b0; hold = 1'b0; sel = 3'd0;
      tick();
      en = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (c == 39) en = 1'b0;
         #1;
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== exp_sig(i)) begin failures++; $display("FAIL abort_model dut%0d c=%0d: got %h expected %h", i, c, obs[i], exp_sig(i)); end
         end
      end
      tick();
      #1;
      checks++;
      if ({row_a, idx_a, done_a} !== 12'h000) begin failures++; $display("FAIL abort_idle: got row=%h idx=%0d done=%b expected 00/0/0", row_a, idx_a, done_a); end
      en = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         #1;
         if (c == 2) begin
            checks++;
            if ({row_a, idx_a} !== {8'h01, 3'd0}) begin failures++; $display("FAIL abort_restart: got row=%h idx=%0d expected 01/0", row_a, idx_a); end
         end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== exp_sig(i)) begin failures++; $display("FAIL restart_model dut%0d c=%0d: got %h expected %h", i, c, obs[i], exp_sig(i)); end
         end
      end
   endtask

   task automatic test_err();
      int nerr;
      en = 1'b0; mode = 1'b1; hold = 1'b0; sel = 3'd6;
      tick();
      en = 1'b1; nerr = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (c == 8) sel = 3'd4;
         #1;
         if (c < 9) begin
            nerr += int'(err_c);
            checks++;
            if ({row_c, idx_c} !== 8'h00) begin failures++; $display("FAIL err_rows c=%0d: got row=%h idx=%0d expected 00/0", c, row_c, idx_c); end
         end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== exp_sig(i)) begin failures++; $display("FAIL err_model dut%0d c=%0d: got %h expected %h", i, c, obs[i], exp_sig(i)); end
         end
      end
      checks++;
      if (nerr !== 3) begin failures++; $display("FAIL err_count: got %0d expected 3", nerr); end
   endtask

   task automatic test_active_low();
      logic [7:0] exp_row;
      en = 1'b0; mode = 1'b0; hold = 1'b0; sel = 3'd0;
      tick();
      en = 1'b1;
      for (int c = 0; c < 70; c++) begin
         tick();
         #1;
         exp_row = ~(8'h01 << ((c / 4) % 8));
         checks++;
         if (row_b !== exp_row) begin failures++; $display("FAIL active_low_row c=%0d: got %h expected %h", c, row_b, exp_row); end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== exp_sig(i)) begin failures++; $display("FAIL active_low_model dut%0d c=%0d: got %h expected %h", i, c, obs[i], exp_sig(i)); end
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (row_b !== 8'hFF) begin failures++; $display("FAIL async_reset_b: got %h expected ff", row_b); end
      checks++;
      if ({row_c, idx_c, idx_b} !== 11'h000) begin failures++; $display("FAIL async_reset_c: got row=%h idx_c=%0d idx_b=%0d expected 0", row_c, idx_c, idx_b); end
      for (int i = 0; i < 3; i++) m_reset(i);
      @(negedge clk);
      rst_n = 1'b1;
      en = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         tick();
         en = ($urandom_range(0, 24) != 0);
         if ($urandom_range(0, 9) == 0) mode = ~mode;
         hold = ($urandom_range(0, 5) == 0);
         sel = 3'($urandom_range(0, 7));
         #1;
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== exp_sig(i)) begin failures++; $display("FAIL random_model dut%0d c=%0d: got %h expected %h", i, c, obs[i], exp_sig(i)); end
         end
         checks++;
         if ($countones(row_a) > 1 || $countones(~row_b) > 1) begin failures++; $display("FAIL random_onehot c=%0d: got a=%h b=%h", c, row_a, row_b); end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) m_reset(i);
      test_reset();
      test_auto_scan();
      test_manual();
      test_hold();
      test_abort();
      test_err();
      test_active_low();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
